memory_responder: RTL and testbench

MEMORY_RESPONDER -- requirements
Module: memory_responder

---
 rtl/memory_responder_pkg.sv | 25 ++
 rtl/memory_responder_mem_array.sv | 37 +++
 rtl/memory_responder.sv | 116 +++++++++++
 tb/tb_memory_responder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/memory_responder_pkg.sv
// Shared CPU package: default memory geometry, wait-state count and the
// memory responder state encoding used by both the datapath and the responder.
package memory_responder_pkg;

  localparam int DEF_ADDR_W      = 9;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_WAIT_CYCLES = 2;
  localparam int CNT_W           = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    HOLD = 2'd3
  } resp_state_t;

  function automatic logic single_request(input logic rd, input logic wr);
    return rd ^ wr;
  endfunction

  function automatic logic both_requests(input logic rd, input logic wr);
    return rd & wr;
  endfunction

endpackage

// File: rtl/memory_responder_mem_array.sv
// Synchronous single-port word storage with write enable and a registered
// read port; only the read register is cleared, never the storage itself.
module mem_array
  import memory_responder_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rd_clr_n,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] storage [DEPTH];

  always_ff @(posedge clk) begin
    if (en && we) begin
      storage[addr] <= wdata;
    end
  end

  // The read register holds its value across writes and idle cycles.
  always_ff @(posedge clk) begin
    if (!rd_clr_n) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= storage[addr];
    end
  end

endmodule

// File: rtl/memory_responder.sv
// Wait-state memory responder: accepts one level request, waits WAIT_CYCLES,
// performs the access, strobes MemReady and then waits for the request to drop.
module memory_responder
  import memory_responder_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic              Clock,
  input  logic              Clear,
  input  logic              Read,
  input  logic              Write,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] DataIn,
  output logic [DATA_W-1:0] Mdatain,
  output logic              MemReady,
  output logic              Busy,
  output logic              Err
);

  resp_state_t       state;
  resp_state_t       next_state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic              lat_write;
  logic              accept;
  logic              clash;
  logic              mem_en;
  logic              mem_ready_q;
  logic              err_q;

  always_ff @(posedge Clock) begin
    if (!Clear) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A counter that somehow sits at zero in WAIT still escapes to RESP.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    clash      = 1'b0;
    mem_en     = 1'b0;
    case (state)
      IDLE: begin
        if (single_request(Read, Write)) begin
          accept     = 1'b1;
          next_state = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end else if (both_requests(Read, Write)) begin
          clash      = 1'b1;
          next_state = HOLD;
        end
      end
      WAIT: begin
        if (cnt <= CNT_W'(1)) begin
          next_state = RESP;
        end
      end
      RESP: begin
        mem_en     = 1'b1;
        next_state = HOLD;
      end
      HOLD: begin
        if (!Read && !Write) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Request fields are captured only on acceptance, so later input changes are ignored.
  always_ff @(posedge Clock) begin
    if (!Clear) begin
      cnt         <= '0;
      lat_addr    <= '0;
      lat_data    <= '0;
      lat_write   <= 1'b0;
      mem_ready_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      mem_ready_q <= mem_en;
      err_q       <= clash;
      if (accept) begin
        lat_addr  <= Address;
        lat_data  <= DataIn;
        lat_write <= Write;
        cnt       <= CNT_W'(WAIT_CYCLES);
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign MemReady = mem_ready_q;
  assign Err      = err_q;
  assign Busy     = (state != IDLE);

  mem_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mem_array (
    .clk     (Clock),
    .rd_clr_n(Clear),
    .en      (mem_en && Clear),
    .we      (lat_write),
    .addr    (lat_addr),
    .wdata   (lat_data),
    .rdata   (Mdatain)
  );

endmodule

// File: tb/tb_memory_responder.sv
// Directed scoreboard bench for memory_responder: a default build (2 wait
// states) and a zero-wait-state build share clock, reset and address/data.
module tb_memory_responder;

  logic        Clock;
  logic        Clear;
  logic        read0, write0, read1, write1;
  logic [8:0]  Address;
  logic [31:0] DataIn;
  logic [31:0] mdatain0, mdatain1;
  logic        mem_ready0, mem_ready1;
  logic        busy0, busy1;
  logic        err0, err1;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q [$];
  logic [31:0] model [int];
  logic [31:0] last_rd [2];

  memory_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(2)) dut0 (
    .Clock(Clock), .Clear(Clear), .Read(read0), .Write(write0),
    .Address(Address), .DataIn(DataIn), .Mdatain(mdatain0),
    .MemReady(mem_ready0), .Busy(busy0), .Err(err0)
  );

  memory_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(0)) dut1 (
    .Clock(Clock), .Clear(Clear), .Read(read1), .Write(write1),
    .Address(Address), .DataIn(DataIn), .Mdatain(mdatain1),
    .MemReady(mem_ready1), .Busy(busy1), .Err(err1)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int which, input logic rd, input logic wr,
                               input logic [8:0] a, input logic [31:0] d);
    Address = a;
    DataIn  = d;
    if (which == 0) begin
      read0 = rd; write0 = wr;
    end else begin
      read1 = rd; write1 = wr;
    end
  endtask

  function automatic logic ready_of(input int which);
    return (which == 0) ? mem_ready0 : mem_ready1;
  endfunction

  function automatic logic busy_of(input int which);
    return (which == 0) ? busy0 : busy1;
  endfunction

  function automatic logic [31:0] mdata_of(input int which);
    return (which == 0) ? mdatain0 : mdatain1;
  endfunction

  function automatic logic [31:0] model_read(input int which, input logic [8:0] a);
    int key;
    key = which * 512 + int'(a);
    return model.exists(key) ? model[key] : 32'h0;
  endfunction

  // Full four-phase access: drive, wait for MemReady, compare, release.
  task automatic do_access(input int which, input logic rd, input logic [8:0] a,
                           input logic [31:0] d, input int exp_lat,
                           input bit perturb, input string tag);
    int lat;
    logic [31:0] exp_data;
    applyStimulus(which, rd, !rd, a, d);
    if (rd) exp_q.push_back(model_read(which, a));
    else    model[which * 512 + int'(a)] = d;
    @(posedge Clock);
    lat = 0;
    while (lat < 20) begin
      @(negedge Clock);
      if (perturb && lat == 0) applyStimulus(which, rd, !rd, a ^ 9'h001, ~d);
      if (ready_of(which)) break;
      @(posedge Clock);
      lat++;
    end
    checkOutput({tag, " latency"}, lat, exp_lat);
    if (rd) begin
      exp_data = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hBAD0BAD0;
      checkOutput({tag, " read data"}, mdata_of(which), exp_data);
      last_rd[which] = exp_data;
    end else begin
      checkOutput({tag, " mdatain kept"}, mdata_of(which), last_rd[which]);
    end
    applyStimulus(which, 1'b0, 1'b0, a, d);
    @(posedge Clock);
    @(negedge Clock);
    checkOutput({tag, " busy after release"}, busy_of(which), 1'b0);
    checkOutput({tag, " ready one cycle"}, ready_of(which), 1'b0);
  endtask

  initial begin
    int pulses;
    int err_pulses;
    logic [31:0] exp_data;

    last_rd[0] = '0;
    last_rd[1] = '0;
    Clear = 1'b0;
    read0 = 1'b0; write0 = 1'b0; read1 = 1'b0; write1 = 1'b0;
    Address = '0; DataIn = '0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    checkOutput("reset mdatain", mdatain0, 32'h0);
    checkOutput("reset memready", mem_ready0, 1'b0);
    checkOutput("reset busy", busy0, 1'b0);
    checkOutput("reset err", err0, 1'b0);
    checkOutput("reset busy wait0", busy1, 1'b0);
    Clear = 1'b1;
    @(negedge Clock);

    $display("[TB] basic write/read");
    do_access(0, 1'b0, 9'h010, 32'h00000022, 3, 1'b0, "wr 010");
    do_access(0, 1'b1, 9'h010, 32'h0,        3, 1'b0, "rd 010");
    do_access(0, 1'b0, 9'h1FF, 32'hDEADBEEF, 3, 1'b0, "wr 1FF");
    do_access(0, 1'b1, 9'h1FF, 32'h0,        3, 1'b0, "rd 1FF");
    do_access(0, 1'b1, 9'h000, 32'h0,        3, 1'b0, "rd 000");

    $display("[TB] simultaneous read and write");
    do_access(0, 1'b0, 9'h020, 32'h12345678, 3, 1'b0, "wr 020");
    applyStimulus(0, 1'b1, 1'b1, 9'h020, 32'hCAFEF00D);
    @(posedge Clock);
    @(negedge Clock);
    checkOutput("clash err", err0, 1'b1);
    checkOutput("clash busy", busy0, 1'b1);
    pulses = 0;
    err_pulses = 0;
    repeat (5) begin
      @(posedge Clock);
      @(negedge Clock);
      if (mem_ready0) pulses++;
      if (err0) err_pulses++;
    end
    checkOutput("clash no memready", pulses, 0);
    checkOutput("clash err one cycle", err_pulses, 0);
    checkOutput("clash busy in hold", busy0, 1'b1);
    checkOutput("clash mdatain kept", mdatain0, last_rd[0]);
    applyStimulus(0, 1'b0, 1'b0, 9'h020, 32'h0);
    @(posedge Clock);
    @(negedge Clock);
    checkOutput("clash busy released", busy0, 1'b0);
    do_access(0, 1'b1, 9'h020, 32'h0, 3, 1'b0, "rd 020");

    $display("[TB] reset during wait");
    do_access(0, 1'b0, 9'h030, 32'h11110000, 3, 1'b0, "wr 030");
    applyStimulus(0, 1'b0, 1'b1, 9'h030, 32'hAAAA5555);
    @(posedge Clock);
    @(negedge Clock);
    checkOutput("abort busy before", busy0, 1'b1);
    Clear = 1'b0;
    applyStimulus(0, 1'b0, 1'b0, 9'h030, 32'hAAAA5555);
    @(posedge Clock);
    @(negedge Clock);
    checkOutput("abort busy", busy0, 1'b0);
    checkOutput("abort mdatain", mdatain0, 32'h0);
    checkOutput("abort memready", mem_ready0, 1'b0);
    Clear = 1'b1;
    last_rd[0] = '0;
    last_rd[1] = '0;
    pulses = 0;
    repeat (4) begin
      @(posedge Clock);
      @(negedge Clock);
      if (mem_ready0) pulses++;
    end
    checkOutput("abort no memready", pulses, 0);
    do_access(0, 1'b1, 9'h030, 32'h0, 3, 1'b0, "rd 030");

    $display("[TB] held read");
    applyStimulus(0, 1'b1, 1'b0, 9'h1FF, 32'h0);
    exp_q.push_back(model_read(0, 9'h1FF));
    pulses = 0;
    repeat (10) begin
      @(posedge Clock);
      @(negedge Clock);
      if (mem_ready0) begin
        pulses++;
        exp_data = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hBAD0BAD0;
        checkOutput("held read data", mdatain0, exp_data);
        last_rd[0] = exp_data;
      end
    end
    checkOutput("held read pulses", pulses, 1);
    checkOutput("held read busy", busy0, 1'b1);
    applyStimulus(0, 1'b0, 1'b0, 9'h1FF, 32'h0);
    @(posedge Clock);
    @(negedge Clock);
    do_access(0, 1'b1, 9'h1FF, 32'h0, 3, 1'b0, "reraise rd 1FF");

    $display("[TB] inputs ignored after acceptance");
    do_access(0, 1'b0, 9'h040, 32'h5A5A0001, 3, 1'b1, "wr 040 perturbed");
    do_access(0, 1'b1, 9'h041, 32'h0, 3, 1'b0, "rd 041");
    do_access(0, 1'b1, 9'h040, 32'h0, 3, 1'b0, "rd 040");

    $display("[TB] zero wait states");
    do_access(1, 1'b0, 9'h004, 32'h00000024, 1, 1'b0, "w0 wr 004");
    do_access(1, 1'b1, 9'h004, 32'h0,        1, 1'b0, "w0 rd 004");
    checkOutput("w0 other dut idle", busy0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
